// File: rtl/pipe_ctrl_unit.sv
// Main-control decoder, pipelined control carrier and load-use / flush hazard unit
// for the 5-stage MIPS core.
module pipe_ctrl_unit #(
  parameter int OPC_W      = 6,
  parameter int REG_AW     = 5,
  parameter int MEM_STAGES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [OPC_W-1:0]  id_opcode,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              ex_branch_taken,
  output logic              stall,
  output logic              flush_ifid,
  output logic              id_jump,
  output logic              ex_valid,
  output logic [OPC_W+1:0]  ex_ctrl,
  output logic [1:0]        ex_branch,
  output logic              ex_illegal,
  output logic              mem_valid,
  output logic [3:0]        mem_ctrl,
  output logic              wb_valid,
  output logic [1:0]        wb_ctrl,
  output logic [REG_AW-1:0] wb_dst
);

  localparam logic [OPC_W-1:0] OP_RTYPE = OPC_W'(6'b000000);
  localparam logic [OPC_W-1:0] OP_J     = OPC_W'(6'b000010);
  localparam logic [OPC_W-1:0] OP_BEQ   = OPC_W'(6'b000100);
  localparam logic [OPC_W-1:0] OP_BNE   = OPC_W'(6'b000101);
  localparam logic [OPC_W-1:0] OP_ADDI  = OPC_W'(6'b001000);
  localparam logic [OPC_W-1:0] OP_SLTI  = OPC_W'(6'b001010);
  localparam logic [OPC_W-1:0] OP_ANDI  = OPC_W'(6'b001100);
  localparam logic [OPC_W-1:0] OP_ORI   = OPC_W'(6'b001101);
  localparam logic [OPC_W-1:0] OP_LB    = OPC_W'(6'b100000);
  localparam logic [OPC_W-1:0] OP_LW    = OPC_W'(6'b100011);
  localparam logic [OPC_W-1:0] OP_SB    = OPC_W'(6'b101000);
  localparam logic [OPC_W-1:0] OP_SW    = OPC_W'(6'b101011);

  typedef struct packed {
    logic              valid;
    logic [1:0]        mem_read;
    logic [1:0]        mem_write;
    logic              mem_to_reg;
    logic              reg_write;
    logic              alu_src;
    logic [OPC_W-1:0]  alu_op;
    logic              reg_dst;
    logic [1:0]        branch;
    logic              illegal;
    logic [REG_AW-1:0] dst;
  } ex_t;

  typedef struct packed {
    logic              valid;
    logic [1:0]        mem_read;
    logic [1:0]        mem_write;
    logic              mem_to_reg;
    logic              reg_write;
    logic [REG_AW-1:0] dst;
  } mem_t;

  typedef struct packed {
    logic              valid;
    logic              mem_to_reg;
    logic              reg_write;
    logic [REG_AW-1:0] dst;
  } wb_t;

  ex_t  dec;
  ex_t  ex_d;
  ex_t  ex_q;
  mem_t mem_q [MEM_STAGES];
  wb_t  wb_q;

  logic dec_jump;
  logic use_rs;
  logic use_rt;
  logic hazard;
  logic jump_ok;

  function automatic logic load_hit(
    input logic              v,
    input logic [1:0]        mr,
    input logic [REG_AW-1:0] dst,
    input logic [REG_AW-1:0] rs,
    input logic [REG_AW-1:0] rt,
    input logic              urs,
    input logic              urt
  );
    return v && (mr != 2'b00) && (dst != '0) &&
           ((urs && (dst == rs)) || (urt && (dst == rt)));
  endfunction

  function automatic mem_t to_mem(input ex_t s);
    mem_t m;
    m.valid      = s.valid;
    m.mem_read   = s.mem_read;
    m.mem_write  = s.mem_write;
    m.mem_to_reg = s.mem_to_reg;
    m.reg_write  = s.reg_write;
    m.dst        = s.dst;
    return m;
  endfunction

  function automatic wb_t to_wb(input mem_t s);
    wb_t w;
    w.valid      = s.valid;
    w.mem_to_reg = s.mem_to_reg;
    w.reg_write  = s.reg_write;
    w.dst        = s.dst;
    return w;
  endfunction

  // ID: main-control decode
  always_comb begin
    dec          = '0;
    dec_jump     = 1'b0;
    dec.valid    = 1'b1;
    dec.alu_op   = id_opcode;
    case (id_opcode)
      OP_RTYPE: begin
        dec.reg_dst   = 1'b1;
        dec.reg_write = 1'b1;
      end
      OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: begin
        dec.alu_src   = 1'b1;
        dec.reg_write = 1'b1;
      end
      OP_BEQ: dec.branch = 2'b01;
      OP_BNE: dec.branch = 2'b10;
      OP_LW: begin
        dec.mem_read   = 2'b01;
        dec.mem_to_reg = 1'b1;
        dec.alu_src    = 1'b1;
        dec.reg_write  = 1'b1;
      end
      OP_SW: begin
        dec.mem_write = 2'b01;
        dec.alu_src   = 1'b1;
      end
      OP_LB: begin
        dec.mem_read   = 2'b10;
        dec.mem_to_reg = 1'b1;
        dec.alu_src    = 1'b1;
        dec.reg_write  = 1'b1;
      end
      OP_SB: begin
        dec.mem_write = 2'b10;
        dec.alu_src   = 1'b1;
      end
      OP_J: dec_jump = 1'b1;
      default: dec.illegal = 1'b1;
    endcase
    dec.dst = dec.reg_write ? (dec.reg_dst ? id_rd : id_rt) : '0;
  end

  assign use_rs = (id_opcode != OP_J);
  assign use_rt = (id_opcode == OP_RTYPE) || (id_opcode == OP_BEQ) ||
                  (id_opcode == OP_BNE)   || (id_opcode == OP_SW)  ||
                  (id_opcode == OP_SB);

  // Only loads still short of their last MEM stage can feed ID too late.
  always_comb begin
    hazard = load_hit(ex_q.valid, ex_q.mem_read, ex_q.dst,
                      id_rs, id_rt, use_rs, use_rt);
    for (int k = 0; k < MEM_STAGES - 1; k++) begin
      hazard = hazard | load_hit(mem_q[k].valid, mem_q[k].mem_read, mem_q[k].dst,
                                 id_rs, id_rt, use_rs, use_rt);
    end
  end

  assign stall      = !rst && id_valid && !ex_branch_taken && hazard;
  assign jump_ok    = id_valid && dec_jump && !ex_branch_taken;
  assign id_jump    = !rst && jump_ok;
  assign flush_ifid = !rst && (jump_ok || ex_branch_taken);

  always_comb begin
    ex_d = dec;
    if (stall || ex_branch_taken || !id_valid) begin
      ex_d = '0;
    end
  end

  // ID/EX -> MEM stages -> WB; nothing downstream of EX ever holds
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q <= '0;
      for (int k = 0; k < MEM_STAGES; k++) begin
        mem_q[k] <= '0;
      end
      wb_q <= '0;
    end else begin
      ex_q     <= ex_d;
      mem_q[0] <= to_mem(ex_q);
      for (int k = 1; k < MEM_STAGES; k++) begin
        mem_q[k] <= mem_q[k-1];
      end
      wb_q <= to_wb(mem_q[MEM_STAGES-1]);
    end
  end

  assign ex_valid   = ex_q.valid;
  assign ex_ctrl    = {ex_q.alu_src, ex_q.alu_op, ex_q.reg_dst};
  assign ex_branch  = ex_q.branch;
  assign ex_illegal = ex_q.illegal;

  assign mem_valid  = mem_q[MEM_STAGES-1].valid;
  assign mem_ctrl   = {mem_q[MEM_STAGES-1].mem_read, mem_q[MEM_STAGES-1].mem_write};

  assign wb_valid   = wb_q.valid;
  assign wb_ctrl    = {wb_q.mem_to_reg, wb_q.reg_write};
  assign wb_dst     = wb_q.dst;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Bench for pipe_ctrl_unit: two instances (MEM_STAGES=1 and 2) on shared stimulus,
// checked every cycle against an instruction-list pipeline model.
module tb_pipe_ctrl_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, id_valid, ex_branch_taken;
  logic [5:0] id_opcode;
  logic [4:0] id_rs, id_rt, id_rd;

  logic       stall_o [2], flush_o [2], jump_o [2], exv_o [2], exill_o [2];
  logic       memv_o [2], wbv_o [2];
  logic [7:0] exctrl_o [2];
  logic [1:0] exbr_o [2], wbctrl_o [2];
  logic [3:0] memctrl_o [2];
  logic [4:0] wbdst_o [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    pipe_ctrl_unit #(.OPC_W(6), .REG_AW(5), .MEM_STAGES(g + 1)) u_dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode),
      .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .ex_branch_taken(ex_branch_taken),
      .stall(stall_o[g]), .flush_ifid(flush_o[g]), .id_jump(jump_o[g]),
      .ex_valid(exv_o[g]), .ex_ctrl(exctrl_o[g]), .ex_branch(exbr_o[g]),
      .ex_illegal(exill_o[g]), .mem_valid(memv_o[g]), .mem_ctrl(memctrl_o[g]),
      .wb_valid(wbv_o[g]), .wb_ctrl(wbctrl_o[g]), .wb_dst(wbdst_o[g])
    );
  end

  typedef struct {
    bit       valid;
    bit [1:0] mr, mw;
    bit       m2r, rw, asrc, rdst;
    bit [1:0] br;
    bit       ill;
    bit [5:0] op;
    bit [4:0] dst;
  } ins_t;

  // pl[m][0] = EX, pl[m][1..ms] = MEM stages, pl[m][ms+1] = WB, with ms = m+1
  ins_t pl [2][0:3];
  int   errors = 0;
  int   checks = 0;
  bit   last_stall [2];
  int   nst0, nst1;

  function automatic ins_t bubble();
    ins_t b;
    b = '{default: 0};
    return b;
  endfunction

  function automatic ins_t decode(bit [5:0] op, bit [4:0] rt, bit [4:0] rd);
    ins_t d;
    d = '{default: 0};
    d.valid = 1;
    d.op    = op;
    case (op)
      6'h00: begin d.rdst = 1; d.rw = 1; end
      6'h08, 6'h0c, 6'h0d, 6'h0a: begin d.asrc = 1; d.rw = 1; end
      6'h04: d.br = 2'b01;
      6'h05: d.br = 2'b10;
      6'h23: begin d.mr = 2'b01; d.m2r = 1; d.asrc = 1; d.rw = 1; end
      6'h2b: begin d.mw = 2'b01; d.asrc = 1; end
      6'h20: begin d.mr = 2'b10; d.m2r = 1; d.asrc = 1; d.rw = 1; end
      6'h28: begin d.mw = 2'b10; d.asrc = 1; end
      6'h02: ;
      default: d.ill = 1;
    endcase
    d.dst = d.rw ? (d.rdst ? rd : rt) : 5'd0;
    return d;
  endfunction

  function automatic bit exp_stall(int m, bit r, bit v, bit [5:0] op,
                                   bit [4:0] rs, bit [4:0] rt, bit bt);
    bit urs, urt, hit;
    urs = (op != 6'h02);
    urt = (op == 6'h00) || (op == 6'h04) || (op == 6'h05) || (op == 6'h2b) || (op == 6'h28);
    hit = 0;
    for (int k = 0; k < m + 1; k++) begin
      ins_t s;
      s = pl[m][k];
      if (s.valid && s.mr != 0 && s.dst != 0 &&
          ((urs && s.dst == rs) || (urt && s.dst == rt)))
        hit = 1;
    end
    return !r && v && !bt && hit;
  endfunction

  task automatic chk(string tag, int m, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[ms=%0d] observed=%0h expected=%0h", tag, m + 1, obs, exp);
    end
  endtask

  task automatic step(bit r, bit v, bit [5:0] op, bit [4:0] rs, bit [4:0] rt,
                      bit [4:0] rd, bit bt);
    bit es [2];
    bit ej, ef;
    rst = r; id_valid = v; id_opcode = op;
    id_rs = rs; id_rt = rt; id_rd = rd; ex_branch_taken = bt;
    #1;
    ej = !r && v && (op == 6'h02) && !bt;
    ef = !r && (ej || bt);
    for (int m = 0; m < 2; m++) begin
      es[m] = exp_stall(m, r, v, op, rs, rt, bt);
      chk("stall", m, 32'(stall_o[m]), 32'(es[m]));
      chk("flush_ifid", m, 32'(flush_o[m]), 32'(ef));
      chk("id_jump", m, 32'(jump_o[m]), 32'(ej));
      last_stall[m] = stall_o[m];
    end
    @(posedge clk);
    for (int m = 0; m < 2; m++) begin
      if (r) begin
        for (int k = 0; k < 4; k++) pl[m][k] = bubble();
      end else begin
        for (int k = m + 2; k >= 1; k--) pl[m][k] = pl[m][k-1];
        pl[m][0] = (es[m] || bt || !v) ? bubble() : decode(op, rt, rd);
      end
    end
    #1;
    for (int m = 0; m < 2; m++) begin
      ins_t e, mm, w;
      e  = pl[m][0];
      mm = pl[m][m + 1];
      w  = pl[m][m + 2];
      chk("ex_valid", m, 32'(exv_o[m]), 32'(e.valid));
      chk("ex_ctrl", m, 32'(exctrl_o[m]), 32'({e.asrc, e.op, e.rdst}));
      chk("ex_branch", m, 32'(exbr_o[m]), 32'(e.br));
      chk("ex_illegal", m, 32'(exill_o[m]), 32'(e.ill));
      chk("mem_valid", m, 32'(memv_o[m]), 32'(mm.valid));
      chk("mem_ctrl", m, 32'(memctrl_o[m]), 32'({mm.mr, mm.mw}));
      chk("wb_valid", m, 32'(wbv_o[m]), 32'(w.valid));
      chk("wb_ctrl", m, 32'(wbctrl_o[m]), 32'({w.m2r, w.rw}));
      chk("wb_dst", m, 32'(wbdst_o[m]), 32'(w.dst));
    end
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(0, 0, 6'h00, 0, 0, 0, 0);
  endtask

  bit [5:0] ops [12] = '{6'h00, 6'h08, 6'h0c, 6'h0d, 6'h0a, 6'h04,
                         6'h05, 6'h23, 6'h2b, 6'h20, 6'h28, 6'h02};

  initial begin
    for (int m = 0; m < 2; m++)
      for (int k = 0; k < 4; k++) pl[m][k] = bubble();
    rst = 1; id_valid = 0; id_opcode = 0; id_rs = 0; id_rt = 0; id_rd = 0;
    ex_branch_taken = 0;

    // reset with a random opcode in ID
    step(1, 1, 6'($urandom), 5'd1, 5'd2, 5'd3, 0);
    step(1, 1, 6'($urandom), 5'd1, 5'd2, 5'd3, 0);
    chk("reset_ex_valid", 0, 32'(exv_o[0]), 32'd0);
    chk("reset_wb_ctrl", 1, 32'(wbctrl_o[1]), 32'd0);

    // R-type rd=3 through the MEM_STAGES=1 pipe
    step(0, 1, 6'h00, 5'd1, 5'd2, 5'd3, 0);
    chk("rtype_ex_ctrl", 0, 32'(exctrl_o[0]), 32'h01);
    idle(1);
    chk("rtype_mem_ctrl", 0, 32'(memctrl_o[0]), 32'h0);
    idle(1);
    chk("rtype_wb_ctrl", 0, 32'(wbctrl_o[0]), 32'b01);
    chk("rtype_wb_dst", 0, 32'(wbdst_o[0]), 32'd3);
    idle(2);

    // lw rt=5 then add rs=5 held in ID while stalled
    step(0, 1, 6'h23, 5'd1, 5'd5, 5'd0, 0);
    nst0 = 0; nst1 = 0;
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 6'h00, 5'd5, 5'd2, 5'd6, 0);
      nst0 += int'(last_stall[0]);
      nst1 += int'(last_stall[1]);
    end
    chk("loaduse_stall_cycles", 0, 32'(nst0), 32'd1);
    chk("loaduse_stall_cycles", 1, 32'(nst1), 32'd2);
    idle(4);

    // load to r0 never stalls; store after load does
    step(0, 1, 6'h23, 5'd1, 5'd0, 5'd0, 0);
    step(0, 1, 6'h00, 5'd0, 5'd0, 5'd7, 0);
    chk("r0_no_stall", 0, 32'(last_stall[0]), 32'd0);
    idle(3);
    step(0, 1, 6'h23, 5'd1, 5'd5, 5'd0, 0);
    step(0, 1, 6'h2b, 5'd1, 5'd5, 5'd0, 0);
    chk("sw_after_lw_stall", 0, 32'(last_stall[0]), 32'd1);
    idle(4);

    // taken branch beats a load-use stall
    step(0, 1, 6'h23, 5'd1, 5'd5, 5'd0, 0);
    step(0, 1, 6'h00, 5'd5, 5'd2, 5'd6, 1);
    chk("branch_beats_stall", 0, 32'(last_stall[0]), 32'd0);
    chk("branch_kills_ex", 0, 32'(exv_o[0]), 32'd0);
    idle(3);

    // jump, jump killed by taken branch, illegal opcode
    step(0, 1, 6'h02, 5'd0, 5'd0, 5'd0, 0);
    step(0, 1, 6'h02, 5'd0, 5'd0, 5'd0, 1);
    step(0, 1, 6'h3f, 5'd1, 5'd2, 5'd3, 0);
    chk("illegal_ex_ctrl", 0, 32'(exctrl_o[0]), 32'h7e);
    chk("illegal_flag", 1, 32'(exill_o[1]), 32'd1);
    idle(4);

    // reset in the middle of a stall discards everything
    step(0, 1, 6'h20, 5'd1, 5'd4, 5'd0, 0);
    step(0, 1, 6'h00, 5'd4, 5'd4, 5'd4, 0);
    step(1, 1, 6'h00, 5'd4, 5'd4, 5'd4, 0);
    idle(4);

    // randomized traffic on a small register set to provoke hazards
    for (int i = 0; i < 600; i++) begin
      int idx;
      idx = $urandom_range(0, 12);
      step(($urandom_range(0, 39) == 0),
           ($urandom_range(0, 4) != 0),
           (idx == 12) ? 6'($urandom) : ops[idx],
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           5'($urandom_range(0, 3)),
           ($urandom_range(0, 6) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
